input_stream_selector: RTL and testbench

Parametrised, sequential successor of the combinational digit selector. On a start command it snapshots one of two sources, either the main data word or the packed register-file word. It then streams a programmable run of DIGIT_W-bit digits from a start index, with auto-increment, wrap-around and a valid/ready handshake. It sits between the operand sources and the digit-serial datapath, which consumes one digit per accepted transfer.

---
 rtl/input_stream_selector_pkg.sv | 16 +
 rtl/input_digit_mux.sv | 22 ++
 rtl/input_stream_selector.sv | 147 ++++++++++++++
 tb/tb_input_stream_selector.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_stream_selector_pkg.sv
// Shared types and constants for the digit stream selector.
// State encoding, source-select codes and the default digit width.
package input_stream_selector_pkg;

  localparam int DIGIT_W_DEF = 4;

  localparam logic ORIG_MAIN = 1'b0;
  localparam logic ORIG_REGS = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_e;

endpackage

// File: rtl/input_digit_mux.sv
// Combinational indexed digit select over a width-parametrised word.
// Digit 0 is the least significant digit; out-of-range indices give 0.
module input_digit_mux #(
  parameter int W       = 256,
  parameter int DIGIT_W = 4,
  parameter int IDX_W   = 6
) (
  input  logic [W-1:0]       word,
  input  logic [IDX_W-1:0]   idx,
  output logic [DIGIT_W-1:0] digit
);

  localparam int N = W / DIGIT_W;

  always_comb begin
    digit = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IDX_W'(i)) digit = word[i*DIGIT_W +: DIGIT_W];
    end
  end

endmodule

// File: rtl/input_stream_selector.sv
// Snapshots one of two operand sources and streams a run of digits
// from a start index with wrap-around and a valid/ready handshake.
module input_stream_selector
  import input_stream_selector_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int REGS_W  = 256,
  parameter int DIGIT_W = DIGIT_W_DEF,
  parameter int CNT_W   = 8,
  localparam int MAIN_N = DATA_W / DIGIT_W,
  localparam int REGS_N = REGS_W / DIGIT_W,
  localparam int IDX_W  = $clog2(REGS_N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wStart,
  input  logic               wSelecOrigin,
  input  logic [DATA_W-1:0]  wData,
  input  logic [REGS_W-1:0]  wDataRegs,
  input  logic [IDX_W-1:0]   wStartIdx,
  input  logic [CNT_W-1:0]   wCount,
  input  logic               wReady,
  output logic [DIGIT_W-1:0] r,
  output logic               rValid,
  output logic               rLast,
  output logic               rDone,
  output logic               rBusy
);

  state_e              state_q, state_d;
  logic [REGS_W-1:0]   snap_q, snap_d;
  logic                orig_q, orig_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [DIGIT_W-1:0]  r_q, r_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [31:0]         n_new, n_cur;
  logic [IDX_W-1:0]    idx_start, idx_inc;

  always_comb begin
    n_new = (wSelecOrigin == ORIG_REGS) ? 32'(REGS_N) : 32'(MAIN_N);
    n_cur = (orig_q == ORIG_REGS) ? 32'(REGS_N) : 32'(MAIN_N);
    idx_start = IDX_W'(32'(wStartIdx) % n_new);
    if (32'(idx_q) + 32'd1 >= n_cur) idx_inc = '0;
    else idx_inc = idx_q + IDX_W'(1);
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    orig_d  = orig_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (wStart) begin
          orig_d = wSelecOrigin;
          snap_d = (wSelecOrigin == ORIG_REGS) ? wDataRegs
                                               : REGS_W'(wData);
          idx_d  = idx_start;
          rem_d  = wCount;
          busy_d = 1'b1;
          if (wCount == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_STREAM;
            valid_d = 1'b1;
            last_d  = (wCount == CNT_W'(1));
          end
        end
      end
      S_STREAM: begin
        if (valid_q && wReady) begin
          idx_d = idx_inc;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            last_d = (rem_q == CNT_W'(2));
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The digit register is fed from the next snapshot/index so the
  // first digit appears in the cycle right after the start edge.
  input_digit_mux #(
    .W       (REGS_W),
    .DIGIT_W (DIGIT_W),
    .IDX_W   (IDX_W)
  ) u_mux (
    .word  (snap_d),
    .idx   (idx_d),
    .digit (r_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      orig_q  <= ORIG_MAIN;
      idx_q   <= '0;
      rem_q   <= '0;
      r_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      orig_q  <= orig_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      r_q     <= r_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign r      = r_q;
  assign rValid = valid_q;
  assign rLast  = last_q;
  assign rDone  = done_q;
  assign rBusy  = busy_q;

endmodule

// File: tb/tb_input_stream_selector.sv
// Directed scenario bench for the digit stream selector.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_input_stream_selector;

  logic         clk;
  logic         reset;
  logic         wStart;
  logic         wSelecOrigin;
  logic [63:0]  wData;
  logic [255:0] wDataRegs;
  logic [5:0]   wStartIdx;
  logic [7:0]   wCount;
  logic         wReady;
  logic [3:0]   r;
  logic         rValid, rLast, rDone, rBusy;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] MAIN_WORD = 64'h0123456789abcdef;
  localparam logic [255:0] REGS_WORD =
    256'h6789abcdef0123456789abcdef0123456789abcdef0123456789abcdef012345;

  input_stream_selector dut (
    .clk          (clk),
    .reset        (reset),
    .wStart       (wStart),
    .wSelecOrigin (wSelecOrigin),
    .wData        (wData),
    .wDataRegs    (wDataRegs),
    .wStartIdx    (wStartIdx),
    .wCount       (wCount),
    .wReady       (wReady),
    .r            (r),
    .rValid       (rValid),
    .rLast        (rLast),
    .rDone        (rDone),
    .rBusy        (rBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives a start command for one edge; returns in cycle k+1.
  task automatic start_run(input logic org, input logic [5:0] idx,
                           input logic [7:0] cnt);
    @(negedge clk);
    wSelecOrigin = org;
    wStartIdx    = idx;
    wCount       = cnt;
    wStart       = 1'b1;
    @(negedge clk);
    wStart       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({r, rValid, rLast, rDone, rBusy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_async: got %h want 00",
               {r, rValid, rLast, rDone, rBusy});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({r, rValid, rLast, rDone, rBusy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_idle: got %h want 00",
               {r, rValid, rLast, rDone, rBusy});
    end
  endtask

  task automatic test_main_forward();
    logic [3:0] exp_r [4] = '{4'hf, 4'he, 4'hd, 4'hc};
    wData  = MAIN_WORD;
    wReady = 1'b1;
    start_run(1'b0, 6'd0, 8'd4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({r, rValid, rLast, rDone, rBusy} !==
          {exp_r[i], 1'b1, (i == 3), 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL fwd_digit%0d: got r=%h v=%b l=%b d=%b b=%b want r=%h l=%b",
                 i, r, rValid, rLast, rDone, rBusy, exp_r[i], (i == 3));
      end
      @(negedge clk);
    end
    checks++;
    if ({rValid, rDone, rBusy} !== 3'b011) begin
      errors++;
      $display("FAIL fwd_done: got v/d/b=%b want 011",
               {rValid, rDone, rBusy});
    end
    @(negedge clk);
    checks++;
    if ({rValid, rDone, rBusy} !== 3'b000) begin
      errors++;
      $display("FAIL fwd_idle: got v/d/b=%b want 000",
               {rValid, rDone, rBusy});
    end
  endtask

  task automatic test_regs_wrap();
    logic [3:0] exp_r [4] = '{4'h7, 4'h6, 4'h5, 4'h4};
    wDataRegs = REGS_WORD;
    wReady    = 1'b1;
    start_run(1'b1, 6'd62, 8'd4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({r, rValid, rLast} !== {exp_r[i], 1'b1, (i == 3)}) begin
        errors++;
        $display("FAIL wrap_digit%0d: got r=%h v=%b l=%b want r=%h v=1 l=%b",
                 i, r, rValid, rLast, exp_r[i], (i == 3));
      end
      @(negedge clk);
    end
    checks++;
    if (rDone !== 1'b1) begin
      errors++;
      $display("FAIL wrap_done: got %b want 1", rDone);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_r [5] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'hf};
    logic       exp_l [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       pat   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int xfers = 0;
    wData  = MAIN_WORD;
    wReady = 1'b1;
    start_run(1'b0, 6'd14, 8'd3);
    for (int c = 0; c < 5; c++) begin
      wReady = pat[c];
      checks++;
      if ({r, rValid, rLast} !== {exp_r[c], 1'b1, exp_l[c]}) begin
        errors++;
        $display("FAIL bp_cycle%0d: got r=%h v=%b l=%b want r=%h v=1 l=%b",
                 c, r, rValid, rLast, exp_r[c], exp_l[c]);
      end
      if (rValid && wReady) xfers++;
      @(negedge clk);
    end
    wReady = 1'b1;
    checks++;
    if ({rValid, rDone} !== 2'b01) begin
      errors++;
      $display("FAIL bp_done: got v/d=%b want 01", {rValid, rDone});
    end
    checks++;
    if (xfers !== 3) begin
      errors++;
      $display("FAIL bp_xfers: got %0d want 3", xfers);
    end
    @(negedge clk);
  endtask

  task automatic test_snapshot();
    logic [3:0] exp_r [4] = '{4'hf, 4'he, 4'hd, 4'hc};
    wData  = MAIN_WORD;
    wReady = 1'b1;
    start_run(1'b0, 6'd0, 8'd4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({r, rValid} !== {exp_r[i], 1'b1}) begin
        errors++;
        $display("FAIL snap_digit%0d: got r=%h v=%b want r=%h v=1",
                 i, r, rValid, exp_r[i]);
      end
      wStart       = (i == 1);
      wSelecOrigin = (i == 1);
      if (i == 1) wData = '1;
      @(negedge clk);
    end
    wStart       = 1'b0;
    wSelecOrigin = 1'b0;
    checks++;
    if (rDone !== 1'b1) begin
      errors++;
      $display("FAIL snap_done: got %b want 1", rDone);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({rValid, rDone, rBusy} !== 3'b000) begin
      errors++;
      $display("FAIL snap_norestart: got v/d/b=%b want 000",
               {rValid, rDone, rBusy});
    end
    wData = MAIN_WORD;
  endtask

  task automatic test_zero_count();
    wReady = 1'b1;
    start_run(1'b0, 6'd3, 8'd0);
    checks++;
    if ({rValid, rDone, rBusy} !== 3'b011) begin
      errors++;
      $display("FAIL zero_k1: got v/d/b=%b want 011",
               {rValid, rDone, rBusy});
    end
    @(negedge clk);
    checks++;
    if ({rValid, rDone, rBusy} !== 3'b000) begin
      errors++;
      $display("FAIL zero_k2: got v/d/b=%b want 000",
               {rValid, rDone, rBusy});
    end
  endtask

  task automatic test_reset_mid_run();
    wData  = MAIN_WORD;
    wReady = 1'b1;
    start_run(1'b0, 6'd0, 8'd8);
    @(negedge clk);
    checks++;
    if ({r, rValid} !== {4'he, 1'b1}) begin
      errors++;
      $display("FAIL rst_pre: got r=%h v=%b want r=e v=1", r, rValid);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({r, rValid, rLast, rDone, rBusy} !== 8'h00) begin
      errors++;
      $display("FAIL rst_async: got %h want 00",
               {r, rValid, rLast, rDone, rBusy});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({rValid, rDone, rBusy} !== 3'b000) begin
      errors++;
      $display("FAIL rst_nodone: got v/d/b=%b want 000",
               {rValid, rDone, rBusy});
    end
    start_run(1'b0, 6'd5, 8'd2);
    checks++;
    if ({r, rValid, rLast} !== {4'ha, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rst_rerun0: got r=%h v=%b l=%b want r=a v=1 l=0",
               r, rValid, rLast);
    end
    @(negedge clk);
    checks++;
    if ({r, rValid, rLast} !== {4'h9, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL rst_rerun1: got r=%h v=%b l=%b want r=9 v=1 l=1",
               r, rValid, rLast);
    end
    @(negedge clk);
    checks++;
    if ({rValid, rDone} !== 2'b01) begin
      errors++;
      $display("FAIL rst_rerun_done: got v/d=%b want 01", {rValid, rDone});
    end
    @(negedge clk);
  endtask

  initial begin
    wStart       = 1'b0;
    wSelecOrigin = 1'b0;
    wData        = '0;
    wDataRegs    = '0;
    wStartIdx    = '0;
    wCount       = '0;
    wReady       = 1'b0;
    test_reset();
    test_main_forward();
    test_regs_wrap();
    test_backpressure();
    test_snapshot();
    test_zero_count();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
